// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up command sequencer: deselect wait, precharge-all, N auto-refreshes,
// load-mode-register, then hands the command pins to the controller via sdr_init_done.
module sdram_init_sequencer #(
    parameter int                T_PWR     = 4,
    parameter int                T_RP      = 2,
    parameter int                N_REFRESH = 8,
    parameter int                T_RFC     = 7,
    parameter int                T_MRD     = 2,
    parameter int                ADDR_W    = 13,
    parameter logic [ADDR_W-1:0] MODE_REG  = ADDR_W'(13'h033)
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              init_req,
    output logic              sdr_cke,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic [1:0]        sdr_ba,
    output logic              sdr_init_done
);
    // state       | meaning
    // ST_RESET    | held in reset, first edge after release loads the power-up wait
    // ST_PWR_WAIT | deselect for T_PWR cycles
    // ST_PRE      | precharge-all issued
    // ST_RP_WAIT  | deselect for T_RP cycles
    // ST_REF      | auto-refresh issued
    // ST_RFC_WAIT | deselect for T_RFC cycles, then next refresh or mode-register load
    // ST_MRS      | load-mode-register issued
    // ST_MRD_WAIT | deselect for T_MRD cycles
    // ST_DONE     | sequence complete, controller owns the pins
    // ST_REINIT   | re-init request accepted, precharge follows on the next edge

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(T_PWR, T_RP), max2(T_RFC, T_MRD));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REF_W   = $clog2(N_REFRESH + 1);

    localparam logic [CNT_W-1:0]  LD_PWR   = CNT_W'(T_PWR - 1);
    localparam logic [CNT_W-1:0]  LD_RP    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0]  LD_RFC   = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0]  LD_MRD   = CNT_W'(T_MRD - 1);
    localparam logic [REF_W-1:0]  REF_LAST = REF_W'(N_REFRESH);
    localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(1) << 10;

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_PWR_WAIT,
        ST_PRE,
        ST_RP_WAIT,
        ST_REF,
        ST_RFC_WAIT,
        ST_MRS,
        ST_MRD_WAIT,
        ST_DONE,
        ST_REINIT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [REF_W-1:0]  ref_cnt;
    logic [3:0]        cmd;

    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd;

    // Outputs are registered alongside the state, so each branch drives the
    // command that belongs to the state being entered.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state         <= ST_RESET;
            cnt           <= '0;
            ref_cnt       <= '0;
            sdr_cke       <= 1'b0;
            cmd           <= CMD_DESEL;
            sdr_addr      <= '0;
            sdr_ba        <= '0;
            sdr_init_done <= 1'b0;
        end else begin
            sdr_cke       <= 1'b1;
            cmd           <= CMD_DESEL;
            sdr_addr      <= '0;
            sdr_ba        <= '0;
            sdr_init_done <= 1'b0;
            case (state)
                ST_RESET: begin
                    state <= ST_PWR_WAIT;
                    cnt   <= LD_PWR;
                end
                ST_PWR_WAIT: begin
                    if (cnt == '0) begin
                        state    <= ST_PRE;
                        cmd      <= CMD_PRE;
                        sdr_addr <= PRE_ADDR;
                        ref_cnt  <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PRE: begin
                    state <= ST_RP_WAIT;
                    cnt   <= LD_RP;
                end
                ST_RP_WAIT: begin
                    if (cnt == '0) begin
                        state   <= ST_REF;
                        cmd     <= CMD_REF;
                        ref_cnt <= ref_cnt + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_REF: begin
                    state <= ST_RFC_WAIT;
                    cnt   <= LD_RFC;
                end
                ST_RFC_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (ref_cnt == REF_LAST) begin
                        state    <= ST_MRS;
                        cmd      <= CMD_LMR;
                        sdr_addr <= MODE_REG;
                    end else begin
                        state   <= ST_REF;
                        cmd     <= CMD_REF;
                        ref_cnt <= ref_cnt + 1'b1;
                    end
                end
                ST_MRS: begin
                    state <= ST_MRD_WAIT;
                    cnt   <= LD_MRD;
                end
                ST_MRD_WAIT: begin
                    if (cnt == '0) begin
                        state         <= ST_DONE;
                        sdr_init_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    sdr_init_done <= 1'b1;
                    if (init_req) state <= ST_REINIT;
                end
                ST_REINIT: begin
                    state    <= ST_PRE;
                    cmd      <= CMD_PRE;
                    sdr_addr <= PRE_ADDR;
                    ref_cnt  <= '0;
                end
                default: state <= ST_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Bench for sdram_init_sequencer: default and all-minimum parameter instances checked
// against an arithmetic model of the command schedule, plus fixed timing vectors.
module tb_sdram_init_sequencer;

    logic sdram_clk    = 1'b0;
    logic sdram_resetn = 1'b0;
    logic init_req     = 1'b0;

    always #5 sdram_clk = ~sdram_clk;

    logic        d0_cke, d0_cs_n, d0_ras_n, d0_cas_n, d0_we_n, d0_done;
    logic [12:0] d0_addr;
    logic [1:0]  d0_ba;
    logic        d1_cke, d1_cs_n, d1_ras_n, d1_cas_n, d1_we_n, d1_done;
    logic [12:0] d1_addr;
    logic [1:0]  d1_ba;

    sdram_init_sequencer dut0 (
        .sdram_clk    (sdram_clk),
        .sdram_resetn (sdram_resetn),
        .init_req     (init_req),
        .sdr_cke      (d0_cke),
        .sdr_cs_n     (d0_cs_n),
        .sdr_ras_n    (d0_ras_n),
        .sdr_cas_n    (d0_cas_n),
        .sdr_we_n     (d0_we_n),
        .sdr_addr     (d0_addr),
        .sdr_ba       (d0_ba),
        .sdr_init_done(d0_done)
    );

    sdram_init_sequencer #(
        .T_PWR(1), .T_RP(1), .N_REFRESH(1), .T_RFC(1), .T_MRD(1)
    ) dut1 (
        .sdram_clk    (sdram_clk),
        .sdram_resetn (sdram_resetn),
        .init_req     (init_req),
        .sdr_cke      (d1_cke),
        .sdr_cs_n     (d1_cs_n),
        .sdr_ras_n    (d1_ras_n),
        .sdr_cas_n    (d1_cas_n),
        .sdr_we_n     (d1_we_n),
        .sdr_addr     (d1_addr),
        .sdr_ba       (d1_ba),
        .sdr_init_done(d1_done)
    );

    // {cke, cs/ras/cas/we_n, addr, ba, init_done}
    logic [20:0] obs [2];
    assign obs[0] = {d0_cke, d0_cs_n, d0_ras_n, d0_cas_n, d0_we_n, d0_addr, d0_ba, d0_done};
    assign obs[1] = {d1_cke, d1_cs_n, d1_ras_n, d1_cas_n, d1_we_n, d1_addr, d1_ba, d1_done};

    localparam logic [20:0] RESET_OUT = {1'b0, 4'b1111, 13'h0, 2'b00, 1'b0};

    int p_pwr  [2] = '{4, 1};
    int p_rp   [2] = '{2, 1};
    int p_nref [2] = '{8, 1};
    int p_rfc  [2] = '{7, 1};
    int p_mrd  [2] = '{2, 1};

    bit started [2];
    int edge_n  [2];
    int pre_e   [2];
    int req_e   [2];

    int total = 0;
    int bad   = 0;
    int phase = 0;
    int hits  = 0;

    typedef struct {
        int          phase;
        int          dut;
        int          edge_at;
        logic [20:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [20:0] mk(input logic [3:0] cmd, input logic [12:0] addr, input logic done);
        return {1'b1, cmd, addr, 2'b00, done};
    endfunction

    function automatic int lmr_rel(input int d);
        return 1 + p_rp[d] + p_nref[d] * (1 + p_rfc[d]);
    endfunction

    function automatic int done_rel(input int d);
        return lmr_rel(d) + 1 + p_mrd[d];
    endfunction

    // Expected pins at an edge offset rel from the precharge command.
    function automatic logic [20:0] model(input int d, input int rel);
        int          per;
        int          r;
        logic [3:0]  cmd;
        logic [12:0] a;
        per = 1 + p_rfc[d];
        r   = rel - 1 - p_rp[d];
        cmd = 4'b1111;
        a   = 13'h0;
        if (rel == 0) begin
            cmd = 4'b0010;
            a   = 13'h400;
        end else if (r >= 0 && r < p_nref[d] * per && (r % per) == 0) begin
            cmd = 4'b0001;
        end else if (rel == lmr_rel(d)) begin
            cmd = 4'b0000;
            a   = 13'h033;
        end
        return mk(cmd, a, rel >= done_rel(d));
    endfunction

    function automatic logic [20:0] expected(input int d);
        logic [20:0] e;
        if (!started[d]) return RESET_OUT;
        e = model(d, edge_n[d] - pre_e[d]);
        if (edge_n[d] == req_e[d]) e[0] = 1'b1;
        return e;
    endfunction

    task automatic compare(input string name, input int d, input logic [20:0] got, input logic [20:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d edge=%0d got=%h exp=%h", name, d, edge_n[d], got, exp);
        end
    endtask

    task automatic update_model();
        for (int d = 0; d < 2; d++) begin
            if (!sdram_resetn) begin
                started[d] = 1'b0;
            end else if (!started[d]) begin
                started[d] = 1'b1;
                edge_n[d]  = 0;
                pre_e[d]   = p_pwr[d];
                req_e[d]   = -100;
            end else begin
                edge_n[d]++;
                if (init_req && (edge_n[d] - 1 - pre_e[d]) >= done_rel(d)) begin
                    pre_e[d] = edge_n[d] + 1;
                    req_e[d] = edge_n[d];
                end
            end
        end
    endtask

    task automatic tick(input logic rn, input logic rq);
        @(negedge sdram_clk);
        sdram_resetn = rn;
        init_req     = rq;
        @(posedge sdram_clk);
        update_model();
        #1;
        for (int d = 0; d < 2; d++) begin
            compare("model", d, obs[d], expected(d));
            foreach (vecs[i]) begin
                if (started[d] && vecs[i].phase == phase && vecs[i].dut == d && vecs[i].edge_at == edge_n[d]) begin
                    hits++;
                    compare("vec", d, obs[d], vecs[i].exp);
                end
            end
        end
    endtask

    // Reset asserted between edges: pins must return to reset values at once.
    task automatic async_rst();
        #2;
        sdram_resetn = 1'b0;
        #1;
        started[0] = 1'b0;
        started[1] = 1'b0;
        for (int d = 0; d < 2; d++) compare("async_rst", d, obs[d], RESET_OUT);
    endtask

    initial begin
        logic [20:0] desel;
        logic [20:0] pre;
        logic [20:0] refr;
        logic [20:0] lmr;
        logic [20:0] done_out;
        int          vec_count;
        desel    = mk(4'b1111, 13'h0, 1'b0);
        pre      = mk(4'b0010, 13'h400, 1'b0);
        refr     = mk(4'b0001, 13'h0, 1'b0);
        lmr      = mk(4'b0000, 13'h033, 1'b0);
        done_out = mk(4'b1111, 13'h0, 1'b1);

        vecs = '{
            '{1, 0, 0, desel}, '{1, 0, 3, desel}, '{1, 0, 4, pre}, '{1, 0, 5, desel},
            '{1, 0, 7, refr}, '{1, 0, 8, desel}, '{1, 0, 15, refr}, '{1, 0, 63, refr},
            '{1, 0, 64, desel}, '{1, 0, 71, lmr}, '{1, 0, 73, desel}, '{1, 0, 74, done_out},
            '{1, 0, 79, done_out}, '{1, 0, 80, done_out}, '{1, 0, 81, pre}, '{1, 0, 84, refr},
            '{1, 0, 140, refr}, '{1, 0, 148, lmr}, '{1, 0, 150, desel}, '{1, 0, 151, done_out},
            '{1, 1, 0, desel}, '{1, 1, 1, pre}, '{1, 1, 2, desel}, '{1, 1, 3, refr},
            '{1, 1, 4, desel}, '{1, 1, 5, lmr}, '{1, 1, 6, desel}, '{1, 1, 7, done_out},
            '{1, 1, 41, pre}, '{1, 1, 47, done_out}, '{1, 1, 81, pre}, '{1, 1, 87, done_out},
            '{2, 0, 4, pre}, '{2, 0, 7, refr}, '{2, 0, 73, desel}, '{2, 0, 74, done_out},
            '{2, 1, 1, pre}, '{2, 1, 7, done_out}
        };
        vec_count = vecs.size();

        // Long reset hold.
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

        // Full sequence; request at edge 40 is ignored by dut0, accepted at edge 80.
        phase = 1;
        for (int i = 0; i <= 160; i++) tick(1'b1, (i == 40 || i == 80));

        // Mid-refresh reset at edge 30, then a clean restart.
        phase = 0;
        tick(1'b0, 1'b0);
        for (int i = 0; i <= 30; i++) tick(1'b1, 1'b0);
        async_rst();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        phase = 2;
        for (int i = 0; i <= 80; i++) tick(1'b1, 1'b0);
        phase = 0;

        total++;
        if (hits != vec_count) begin
            bad++;
            $display("FAIL vec_hits got=%0d exp=%0d", hits, vec_count);
        end

        // Random requests and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 399) != 0), ($urandom_range(0, 24) == 0));
            if ($urandom_range(0, 999) == 0) begin
                async_rst();
                tick(1'b0, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
